// File: rtl/fs_mon_pkg.sv
// ----------------------------------------------------------------------------
// fs_mon_pkg
// Shared definitions for the fs lock monitor: FSM state encoding, default
// period/tolerance/lock-count constants and the period window test.
// No ports (package).
// ----------------------------------------------------------------------------
package fs_mon_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int DEF_NOMINAL    = 256;
  localparam int DEF_TOL        = 2;
  localparam int DEF_LOCK_COUNT = 4;

  // Inclusive window test: nominal-tol <= period <= nominal+tol
  function automatic logic period_good(input int period, input int nominal, input int tol);
    return (period >= nominal - tol) && (period <= nominal + tol);
  endfunction

endpackage

// File: rtl/fs_lock_monitor_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk_i domain.
// Ports:
//   clk_i   - destination clock
//   rst_ni  - asynchronous active-low reset, clears both stages
//   d_i     - asynchronous input level
//   q_o     - synchronized level (two cycles of latency)
// ----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fs_lock_monitor.sv
// ----------------------------------------------------------------------------
// fs_lock_monitor
// Measures the period of the sample-rate clock fs_in in clk_256fs cycles and
// declares lock after LOCK_COUNT consecutive in-tolerance periods. Drives a
// downstream active-low reset that is released only while locked.
//
// Ports:
//   clk_256fs  in   single clock, all logic on its rising edge
//   rst_n      in   asynchronous active-low reset
//   fs_in      in   sample-rate clock, asynchronous to clk_256fs
//   fs_strobe  out  one-cycle pulse per detected fs_in rising edge
//   locked     out  high while the FSM is in LOCKED
//   rst_out_n  out  downstream reset, released one cycle after locked rises
//   period_q   out  last measured period (CNT_W bits)
//   err_cnt    out  8-bit saturating count of bad periods/timeouts while
//                   acquiring or locked (only with FS_LOCK_MONITOR_ERRCNT_EN)
//
// Build option: define FS_LOCK_MONITOR_ERRCNT_EN to add the err_cnt port.
//
// State table:
//   state   | meaning
//   SEARCH  | no reference edge yet; waiting for the first fs_strobe
//   ACQUIRE | counting consecutive good periods toward LOCK_COUNT
//   LOCKED  | fs period in tolerance; locked high, downstream reset released
// ----------------------------------------------------------------------------
module fs_lock_monitor
  import fs_mon_pkg::*;
#(
  parameter int NOMINAL    = DEF_NOMINAL,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int CNT_W      = 10
) (
  input  logic             clk_256fs,
  input  logic             rst_n,
  input  logic             fs_in,
  output logic             fs_strobe,
  output logic             locked,
  output logic             rst_out_n,
  output logic [CNT_W-1:0] period_q
`ifdef FS_LOCK_MONITOR_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int TMO    = NOMINAL + TOL + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              fs_sync;
  logic              fs_prev_q;
  logic              strobe_q, strobe_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              locked_q, locked_d;
  logic              rst_out_q, rst_out_d;
  logic              good_period;
  logic              timeout;

  sync_2ff u_sync (
    .clk_i  (clk_256fs),
    .rst_ni (rst_n),
    .d_i    (fs_in),
    .q_o    (fs_sync)
  );

  assign strobe_d    = fs_sync & ~fs_prev_q;
  assign good_period = period_good(int'(cnt_q), NOMINAL, TOL);
  // >= rather than == so a counter that has saturated still reads as timed out
  assign timeout     = int'(cnt_q) >= TMO;

  // Counter restarts at 1 right after the strobe so a strobe-to-strobe
  // distance of N cycles leaves exactly N in cnt_q on the next strobe.
  always_comb begin
    cnt_d = cnt_q;
    if (strobe_q) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      SEARCH: begin
        if (strobe_q) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        // An edge wins over a coincident timeout; its period is judged normally
        if (strobe_q) begin
          if (!good_period) begin
            good_d = '0;
          end else if (int'(good_q) + 1 >= LOCK_COUNT) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end else if (timeout) begin
          state_d = SEARCH;
          good_d  = '0;
        end
      end
      LOCKED: begin
        if (strobe_q) begin
          if (!good_period) begin
            state_d = ACQUIRE;
            good_d  = '0;
          end
        end else if (timeout) begin
          state_d = SEARCH;
          good_d  = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
  end

  assign locked_d  = (state_d == LOCKED);
  // Rises one cycle after locked, falls on the same edge as locked
  assign rst_out_d = locked_d & locked_q;

  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      fs_prev_q <= 1'b0;
      strobe_q  <= 1'b0;
      cnt_q     <= '0;
      state_q   <= SEARCH;
      good_q    <= '0;
      locked_q  <= 1'b0;
      rst_out_q <= 1'b0;
      period_q  <= '0;
    end else begin
      fs_prev_q <= fs_sync;
      strobe_q  <= strobe_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      rst_out_q <= rst_out_d;
      // The first strobe after SEARCH has no reference edge behind it
      if (strobe_q && (state_q != SEARCH)) begin
        period_q <= cnt_q;
      end
    end
  end

  assign fs_strobe = strobe_q;
  assign locked    = locked_q;
  assign rst_out_n = rst_out_q;

`ifdef FS_LOCK_MONITOR_ERRCNT_EN
  logic       err_evt;
  logic [7:0] err_q;

  assign err_evt = (state_q != SEARCH) &&
                   ((strobe_q && !good_period) || (!strobe_q && timeout));

  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (err_evt && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_fs_lock_monitor.sv
// ----------------------------------------------------------------------------
// tb_fs_lock_monitor
// Directed bench for fs_lock_monitor. fs_in is generated rise-to-rise with
// exact cycle spacing; every rise is followed by four clk_256fs edges so the
// strobe (edge 3) and the FSM/period update (edge 4) are visible on return.
// A second instance with CNT_W=8 shares the stimulus to exercise saturation.
// ----------------------------------------------------------------------------
module tb_fs_lock_monitor;

  logic       clk_256fs = 1'b0;
  logic       rst_n;
  logic       fs_in;
  logic       fs_strobe, locked, rst_out_n;
  logic [9:0] period_q;
  logic       fs_strobe8, locked8, rst_out_n8;
  logic [7:0] period_q8;
`ifdef FS_LOCK_MONITOR_ERRCNT_EN
  logic [7:0] err_cnt, err_cnt8;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int hi_left  = 0;
  int pend     = 0;

  always #5 clk_256fs = ~clk_256fs;

  fs_lock_monitor dut (
    .clk_256fs (clk_256fs),
    .rst_n     (rst_n),
    .fs_in     (fs_in),
    .fs_strobe (fs_strobe),
    .locked    (locked),
    .rst_out_n (rst_out_n),
    .period_q  (period_q)
`ifdef FS_LOCK_MONITOR_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  fs_lock_monitor #(.CNT_W(8)) dut8 (
    .clk_256fs (clk_256fs),
    .rst_n     (rst_n),
    .fs_in     (fs_in),
    .fs_strobe (fs_strobe8),
    .locked    (locked8),
    .rst_out_n (rst_out_n8),
    .period_q  (period_q8)
`ifdef FS_LOCK_MONITOR_ERRCNT_EN
    ,
    .err_cnt   (err_cnt8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clock: drive fs_in from the remaining high time, sample at edge+1
  task automatic drive_tick();
    fs_in = (hi_left > 0);
    if (hi_left > 0) hi_left--;
    @(posedge clk_256fs);
    #1;
  endtask

  task automatic step();
    drive_tick();
    pend++;
  endtask

  task automatic fs_rise(input int hi);
    hi_left = hi;
    repeat (4) drive_tick();
    pend = 0;
  endtask

  // next rise lands exactly p cycles after the previous one
  task automatic fs_period(input int p, input int hi);
    repeat (p - 4 - pend) drive_tick();
    fs_rise(hi);
  endtask

  initial begin
    rst_n = 1'b0;
    fs_in = 1'b0;
    repeat (3) begin
      @(posedge clk_256fs);
      #1;
    end
    chk("rst_locked",    locked,    0);
    chk("rst_rst_out",   rst_out_n, 0);
    chk("rst_strobe",    fs_strobe, 0);
    chk("rst_period",    period_q,  0);
    chk("rst_period8",   period_q8, 0);
    rst_n = 1'b1;
    repeat (3) drive_tick();

    // first rise: strobe on the third edge only, no period judged
    hi_left = 128;
    drive_tick();
    drive_tick();
    chk("strobe_e2", fs_strobe, 0);
    drive_tick();
    chk("strobe_e3", fs_strobe, 1);
    drive_tick();
    chk("strobe_e4", fs_strobe, 0);
    chk("first_period_q", period_q, 0);
    pend = 0;

    fs_period(256, 128);
    chk("ideal_period_q", period_q, 256);
    chk("sat8_period_q", period_q8, 255);
    chk("ideal_lock_s2", locked, 0);
    fs_period(256, 128);
    fs_period(256, 128);
    chk("ideal_lock_s4", locked, 0);
    fs_period(256, 128);
    chk("ideal_lock_s5", locked, 1);
    chk("ideal_rstout_s5", rst_out_n, 0);
    step();
    chk("ideal_rstout_s5p1", rst_out_n, 1);

    fs_period(254, 128);
    chk("p254_period", period_q, 254);
    chk("p254_locked", locked, 1);
    fs_period(258, 128);
    chk("p258_period", period_q, 258);
    chk("p258_locked", locked, 1);
    fs_period(256, 128);

    fs_period(253, 128);
    chk("p253_period", period_q, 253);
    chk("p253_locked", locked, 0);
    chk("p253_rstout", rst_out_n, 0);
`ifdef FS_LOCK_MONITOR_ERRCNT_EN
    chk("p253_errcnt", err_cnt, 1);
`endif
    repeat (3) fs_period(256, 128);
    chk("p253_relock_3", locked, 0);
    fs_period(256, 128);
    chk("p253_relock_4", locked, 1);

    // 259 coincides with the timeout value: judged as a bad edge -> ACQUIRE
    fs_period(259, 128);
    chk("p259_period", period_q, 259);
    chk("p259_locked", locked, 0);
`ifdef FS_LOCK_MONITOR_ERRCNT_EN
    chk("p259_errcnt", err_cnt, 2);
`endif
    repeat (3) fs_period(256, 128);
    chk("p259_relock_3", locked, 0);
    fs_period(256, 128);
    chk("p259_relock_4", locked, 1);

    // fs_in stuck low: counter hits 259 in the cycle after edge +262
    repeat (258) step();
    chk("stuck_cnt258_locked", locked, 1);
    step();
    chk("stuck_cnt259_locked", locked, 0);
    chk("stuck_cnt259_rstout", rst_out_n, 0);
`ifdef FS_LOCK_MONITOR_ERRCNT_EN
    chk("stuck_errcnt", err_cnt, 3);
`endif
    repeat (20) step();
    // SEARCH: the next rise is a reference edge and must not load period_q
    fs_rise(128);
    chk("search_period_hold", period_q, 256);
    chk("search_locked", locked, 0);
    repeat (3) fs_period(256, 128);
    chk("search_relock_3", locked, 0);
    fs_period(256, 50);
    chk("search_relock_4", locked, 1);

    // 1-cycle glitch: rises 100 then 156 cycles apart
    fs_period(100, 1);
    chk("glitch_period_a", period_q, 100);
    chk("glitch_period8_a", period_q8, 100);
    chk("glitch_locked_a", locked, 0);
    fs_period(156, 128);
    chk("glitch_period_b", period_q, 156);
    chk("glitch_locked_b", locked, 0);
    repeat (3) fs_period(256, 128);
    chk("glitch_relock_3", locked, 0);
    fs_period(256, 128);
    chk("glitch_relock_4", locked, 1);

    // async reset mid-lock
    rst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_rstout", rst_out_n, 0);
    chk("arst_period", period_q, 0);
    chk("arst_strobe", fs_strobe, 0);
    hi_left = 0;
    repeat (3) drive_tick();
    rst_n = 1'b1;
    repeat (2) drive_tick();
    fs_rise(128);
    chk("arst_first_period", period_q, 0);
    repeat (3) fs_period(256, 128);
    chk("arst_relock_3", locked, 0);
    fs_period(256, 128);
    chk("arst_relock_4", locked, 1);
    chk("arst_relock_rstout", rst_out_n, 0);
    step();
    chk("arst_relock_rstout_p1", rst_out_n, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
